stopwatch_ctrl: RTL and testbench

Run-control sequencer for the lab-3 stopwatch/timer display path. It divides `clk` down to a seconds tick and runs a start/pause/clear/load state machine. It keeps an up- or down-counting minutes:seconds value and drives the `minutes`/`seconds` inputs of `display_driver` directly. It sits between the debounced button/switch logic and `display_driver`.

---
 rtl/stopwatch_pkg.sv | 19 +
 rtl/tick_prescaler.sv | 38 +++
 rtl/stopwatch_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types, limits and helpers for the stopwatch run-control sequencer.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StRunning = 2'd1,
        StPaused  = 2'd2,
        StExpired = 2'd3
    } state_t;

    localparam logic [5:0] MAX_SEC = 6'd59;
    localparam logic [5:0] MAX_MIN = 6'd59;

    // Saturate a 6-bit minutes/seconds field to the displayable range.
    function automatic logic [5:0] clamp59(input logic [5:0] v);
        return (v > 6'd59) ? 6'd59 : v;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divide-by-DIV prescaler; tick pulses on the last count while enabled.
module tick_prescaler #(
    parameter int unsigned DIV = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic sync_clr,
    output logic tick
);

    localparam int unsigned W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == LAST);

    // Next count: clear wins, otherwise advance and wrap only while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (sync_clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Start/pause/clear/load sequencer with an up/down mm:ss count for display_driver.
// Optional lap freeze of the displayed value is built when STOPWATCH_LAP_EN is defined.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 100_000_000,
    parameter int unsigned TICK_HZ     = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       load,
    input  logic [5:0] load_min,
    input  logic [5:0] load_sec,
    input  logic       mode,
    input  logic       lap,
    output logic [5:0] minutes,
    output logic [5:0] seconds,
    output logic       running,
    output logic       expired,
    output logic       tick
);

    localparam int unsigned DIV = CLK_FREQ_HZ / TICK_HZ;

    state_t     state_q, state_d;
    logic [5:0] min_q, min_d;
    logic [5:0] sec_q, sec_d;
    logic       dir_q, dir_d;
    logic       pre_tick;
    logic       pre_en;
    logic       pre_clr;

    // Coinciding pulses: only the highest-priority one is acted on.
    logic clr_evt, ld_evt, ss_evt, lap_evt;
    assign clr_evt = clear;
    assign ld_evt  = load & ~clear;
    assign ss_evt  = start_stop & ~clear & ~load;
    assign lap_evt = lap & ~clear & ~load & ~start_stop;

    logic ld_acc;
    logic is_zero;
    logic last_step;
    assign ld_acc    = ld_evt && (state_q != StRunning);
    assign is_zero   = (min_q == 6'd0) && (sec_q == 6'd0);
    // Down-count step that lands on (or is already at) 00:00 ends the run.
    assign last_step = pre_tick && dir_q && (min_q == 6'd0) && (sec_q <= 6'd1);

    assign pre_en  = (state_q == StRunning);
    assign pre_clr = clr_evt || ld_acc || (state_q == StIdle) || (state_q == StExpired);

    tick_prescaler #(
        .DIV (DIV)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .en       (pre_en),
        .sync_clr (pre_clr),
        .tick     (pre_tick)
    );

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        if (clr_evt) begin
            state_d = StIdle;
        end else if (ld_acc) begin
            state_d = (state_q == StExpired) ? StIdle : state_q;
        end else begin
            case (state_q)
                StIdle: begin
                    if (ss_evt) begin
                        state_d = (mode && is_zero) ? StExpired : StRunning;
                    end
                end
                StRunning: begin
                    if (last_step) begin
                        state_d = StExpired;
                    end else if (ss_evt) begin
                        state_d = StPaused;
                    end
                end
                StPaused: begin
                    if (ss_evt) begin
                        state_d = StRunning;
                    end
                end
                StExpired: begin
                    if (ss_evt) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Count and direction next-state: clear, then load, then tick stepping.
    always_comb begin
        min_d = min_q;
        sec_d = sec_q;
        dir_d = dir_q;
        if (clr_evt) begin
            min_d = 6'd0;
            sec_d = 6'd0;
        end else if (ld_acc) begin
            min_d = clamp59(load_min);
            sec_d = clamp59(load_sec);
        end else begin
            if ((state_q == StIdle) && ss_evt) begin
                dir_d = mode;
            end
            if (pre_tick) begin
                if (!dir_q) begin
                    if (sec_q >= MAX_SEC) begin
                        sec_d = 6'd0;
                        min_d = (min_q >= MAX_MIN) ? 6'd0 : min_q + 6'd1;
                    end else begin
                        sec_d = sec_q + 6'd1;
                    end
                end else if (last_step) begin
                    min_d = 6'd0;
                    sec_d = 6'd0;
                end else if (sec_q == 6'd0) begin
                    sec_d = MAX_SEC;
                    min_d = min_q - 6'd1;
                end else begin
                    sec_d = sec_q - 6'd1;
                end
            end
        end
    end

    // Count and direction registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min_q <= 6'd0;
            sec_q <= 6'd0;
            dir_q <= 1'b0;
        end else begin
            min_q <= min_d;
            sec_q <= sec_d;
            dir_q <= dir_d;
        end
    end

`ifdef STOPWATCH_LAP_EN
    logic       frz_q, frz_d;
    logic [5:0] snap_min_q, snap_min_d;
    logic [5:0] snap_sec_q, snap_sec_d;

    // Lap freeze: toggled in RUNNING/PAUSED, released by clear, load or expiry.
    always_comb begin
        frz_d      = frz_q;
        snap_min_d = snap_min_q;
        snap_sec_d = snap_sec_q;
        if (clr_evt || ld_acc || (state_d == StExpired)) begin
            frz_d = 1'b0;
        end else if (lap_evt && ((state_q == StRunning) || (state_q == StPaused))) begin
            frz_d = ~frz_q;
            if (!frz_q) begin
                snap_min_d = min_q;
                snap_sec_d = sec_q;
            end
        end
    end

    // Freeze flag and snapshot registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frz_q      <= 1'b0;
            snap_min_q <= 6'd0;
            snap_sec_q <= 6'd0;
        end else begin
            frz_q      <= frz_d;
            snap_min_q <= snap_min_d;
            snap_sec_q <= snap_sec_d;
        end
    end
`else
    logic unused_lap;
    logic unused_lap_evt;
    logic frz_q;
    logic [5:0] snap_min_q;
    logic [5:0] snap_sec_q;
    assign unused_lap     = lap;
    assign unused_lap_evt = lap_evt;
    assign frz_q          = 1'b0;
    assign snap_min_q     = 6'd0;
    assign snap_sec_q     = 6'd0;
`endif

    // Outputs are decoded from registers only; no input reaches an output.
    always_comb begin
        running = (state_q == StRunning);
        expired = (state_q == StExpired);
        tick    = pre_tick;
        minutes = frz_q ? snap_min_q : min_q;
        seconds = frz_q ? snap_sec_q : sec_q;
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench: directed scenarios plus random pulses against a seconds-based model.
module tb_stopwatch_ctrl;

    localparam int DIV = 10;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_PAU  = 2;
    localparam int M_EXP  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_stop = 1'b0;
    logic       clear = 1'b0;
    logic       load = 1'b0;
    logic [5:0] load_min = 6'd0;
    logic [5:0] load_sec = 6'd0;
    logic       mode = 1'b0;
    logic       lap = 1'b0;
    logic [5:0] minutes;
    logic [5:0] seconds;
    logic       running;
    logic       expired;
    logic       tick;

    int n_checks = 0;
    int n_err    = 0;

    stopwatch_ctrl #(
        .CLK_FREQ_HZ (10),
        .TICK_HZ     (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_stop (start_stop),
        .clear      (clear),
        .load       (load),
        .load_min   (load_min),
        .load_sec   (load_sec),
        .mode       (mode),
        .lap        (lap),
        .minutes    (minutes),
        .seconds    (seconds),
        .running    (running),
        .expired    (expired),
        .tick       (tick)
    );

    always #5 clk = ~clk;

    // Model: count kept as total seconds, prescaler as a phase within the period.
    typedef struct {
        int st;
        int total;
        int phase;
        bit dir;
        bit frz;
        int snap;
    } mdl_t;

    mdl_t m;

    function automatic mdl_t mreset();
        mdl_t r;
        r.st = M_IDLE; r.total = 0; r.phase = 0; r.dir = 0; r.frz = 0; r.snap = 0;
        return r;
    endfunction

    function automatic int clamp(int v);
        return (v > 59) ? 59 : v;
    endfunction

    function automatic mdl_t step(mdl_t c, bit ss, bit clr, bit ld, bit lp,
                                  int lmin, int lsec, bit md);
        mdl_t n;
        bit   tk;
        bit   p_ld, p_ss, p_lp;
        n    = c;
        tk   = (c.st == M_RUN) && (c.phase == DIV - 1);
        p_ld = ld;
        p_ss = ss && !ld;
        p_lp = lp && !ld && !ss;
        if (clr) begin
            n = mreset();
            n.dir  = c.dir;
            n.snap = c.snap;
            return n;
        end
        if (p_ld && c.st != M_RUN) begin
            n.total = clamp(lmin) * 60 + clamp(lsec);
            n.phase = 0;
            n.frz   = 0;
            if (c.st == M_EXP) n.st = M_IDLE;
            return n;
        end
        case (c.st)
            M_IDLE: begin
                if (p_ss) begin
                    n.dir   = md;
                    n.phase = 0;
                    n.st    = (md && c.total == 0) ? M_EXP : M_RUN;
                end
            end
            M_RUN: begin
                n.phase = tk ? 0 : c.phase + 1;
                if (tk) begin
                    if (!c.dir) begin
                        n.total = (c.total + 1) % 3600;
                    end else if (c.total <= 1) begin
                        n.total = 0;
                        n.st    = M_EXP;
                        n.frz   = 0;
                    end else begin
                        n.total = c.total - 1;
                    end
                end
                if (n.st == M_RUN) begin
                    if (p_ss) n.st = M_PAU;
`ifdef STOPWATCH_LAP_EN
                    else if (p_lp) begin
                        n.frz = !c.frz;
                        if (!c.frz) n.snap = c.total;
                    end
`endif
                end
            end
            M_PAU: begin
                if (p_ss) n.st = M_RUN;
`ifdef STOPWATCH_LAP_EN
                else if (p_lp) begin
                    n.frz = !c.frz;
                    if (!c.frz) n.snap = c.total;
                end
`endif
            end
            default: begin
                if (p_ss) n.st = M_IDLE;
            end
        endcase
        if (p_lp && 0) n.frz = 0;
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) m <= mreset();
        else m <= step(m, start_stop, clear, load, lap, int'(load_min), int'(load_sec), mode);
    end

    function automatic int disp_total(mdl_t c);
        return c.frz ? c.snap : c.total;
    endfunction

    task automatic chk(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, away from the rising edge.
    always @(negedge clk) begin
        chk("cyc_minutes", int'(minutes), disp_total(m) / 60);
        chk("cyc_seconds", int'(seconds), disp_total(m) % 60);
        chk("cyc_running", int'(running), (m.st == M_RUN) ? 1 : 0);
        chk("cyc_expired", int'(expired), (m.st == M_EXP) ? 1 : 0);
        chk("cyc_tick", int'(tick), (m.st == M_RUN && m.phase == DIV - 1) ? 1 : 0);
    end

    // Hand-computed expectations, applied to both the DUT and the model.
    task automatic lit(string tag, int mn, int sc, int run, int ex, int tk);
        chk({tag, "_min"}, int'(minutes), mn);
        chk({tag, "_sec"}, int'(seconds), sc);
        chk({tag, "_run"}, int'(running), run);
        chk({tag, "_exp"}, int'(expired), ex);
        chk({tag, "_tick"}, int'(tick), tk);
        chk({tag, "_model"}, disp_total(m), mn * 60 + sc);
    endtask

    // All stimulus changes land 2 time units after a rising edge.
    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulse_ss();
        start_stop = 1'b1; idle(1); start_stop = 1'b0;
    endtask

    task automatic pulse_clr();
        clear = 1'b1; idle(1); clear = 1'b0;
    endtask

    task automatic pulse_ld(int mn, int sc);
        load_min = 6'(mn); load_sec = 6'(sc);
        load = 1'b1; idle(1); load = 1'b0;
    endtask

    task automatic pulse_lap();
        lap = 1'b1; idle(1); lap = 1'b0;
    endtask

    initial begin
        int r;
        idle(3);
        rst = 1'b0;
        lit("reset", 0, 0, 0, 0, 0);

        // First tick DIV cycles after start.
        mode = 1'b0;
        pulse_ss();
        idle(9);
        lit("first_tick", 0, 0, 1, 0, 1);
        idle(1);
        lit("up_0001", 0, 1, 1, 0, 0);
        idle(35);
        lit("up_0004", 0, 4, 1, 0, 0);

        // Up-count wrap at 59:59.
        pulse_clr();
        lit("clr_idle", 0, 0, 0, 0, 0);
        pulse_ld(59, 58);
        lit("load_5958", 59, 58, 0, 0, 0);
        pulse_ss();
        idle(10);
        lit("up_5959", 59, 59, 1, 0, 0);
        idle(10);
        lit("wrap_0000", 0, 0, 1, 0, 0);

        // Down-count to expiry.
        pulse_clr();
        mode = 1'b1;
        pulse_ld(0, 2);
        pulse_ss();
        idle(10);
        lit("dn_0001", 0, 1, 1, 0, 0);
        idle(10);
        lit("dn_expired", 0, 0, 0, 1, 0);
        pulse_ss();
        lit("exp_ack", 0, 0, 0, 0, 0);
        pulse_ss();
        lit("dn_start_zero", 0, 0, 0, 1, 0);
        pulse_ss();
        lit("exp_ack2", 0, 0, 0, 0, 0);

        // Clamp on load; load ignored while running.
        pulse_ld(63, 60);
        lit("clamp", 59, 59, 0, 0, 0);
        mode = 1'b0;
        pulse_ss();
        idle(3);
        pulse_ld(0, 0);
        lit("load_in_run", 59, 59, 1, 0, 0);

        // Pause mid-period, resume: remaining 6 cycles of the period.
        pulse_clr();
        pulse_ss();
        idle(3);
        pulse_ss();
        lit("paused", 0, 0, 0, 0, 0);
        idle(50);
        lit("paused_hold", 0, 0, 0, 0, 0);
        pulse_ss();
        idle(5);
        lit("resume_tick", 0, 0, 1, 0, 1);
        idle(1);
        lit("resume_0001", 0, 1, 1, 0, 0);

        // clear beats start_stop.
        clear = 1'b1; start_stop = 1'b1;
        idle(1);
        clear = 1'b0; start_stop = 1'b0;
        lit("clr_ss", 0, 0, 0, 0, 0);
        idle(12);
        lit("clr_ss_idle", 0, 0, 0, 0, 0);

        // Lap freeze (or ignored lap without the feature).
        pulse_ss();
        idle(30);
        lit("lap_pre", 0, 3, 1, 0, 0);
        pulse_lap();
        idle(30);
`ifdef STOPWATCH_LAP_EN
        lit("lap_frozen", 0, 3, 1, 0, 0);
`else
        lit("lap_ignored", 0, 6, 1, 0, 0);
`endif
        pulse_lap();
        lit("lap_release", 0, 6, 1, 0, 0);

        // Asynchronous reset mid-count, checked before any clock edge.
        #1 rst = 1'b1;
        #1;
        lit("async_rst", 0, 0, 0, 0, 0);
        idle(1);
        rst = 1'b0;
        idle(1);

        // Random pulses, mode flips and load values, checked by the model each cycle.
        for (int i = 0; i < 4000; i++) begin
            r = $urandom_range(0, 99);
            clear      = (r < 2);
            load       = (r >= 2 && r < 8);
            start_stop = (r >= 8 && r < 18);
            lap        = (r >= 18 && r < 24);
            if ($urandom_range(0, 19) == 0) start_stop = 1'b1;
            if ($urandom_range(0, 29) == 0) lap = 1'b1;
            if ($urandom_range(0, 1) == 1) begin
                load_min = 6'($urandom_range(0, 63));
                load_sec = 6'($urandom_range(0, 63));
            end else begin
                load_min = 6'd0;
                load_sec = 6'($urandom_range(0, 4));
            end
            if ($urandom_range(0, 7) == 0) mode = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1499) == 0) begin
                #1 rst = 1'b1;
                #1 rst = 1'b0;
            end
            idle(1);
        end
        clear = 1'b0; load = 1'b0; start_stop = 1'b0; lap = 1'b0;
        idle(2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
